// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and the saturating 2-bit counter rule for the branch predictor write side.
package bpu_pkg;

  typedef logic [15:0] pc_t;

  // Widest table indices an entry can carry; unit parameters must not exceed these.
  localparam int BR_HIDX_W = 5;
  localparam int BR_CIDX_W = 5;

  localparam logic [1:0] CNT_MAX = 2'd3;
  localparam logic [1:0] CNT_MIN = 2'd0;

  typedef struct packed {
    pc_t                  pc;
    logic                 taken;
    pc_t                  target;
    logic [BR_HIDX_W-1:0] hist_idx;
    logic [BR_CIDX_W-1:0] cnt_idx;
    logic [1:0]           cnt_val;
  } br_entry_t;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == CNT_MAX) ? CNT_MAX : cnt + 2'd1;
    else       return (cnt == CNT_MIN) ? CNT_MIN : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute-facing bundle of the branch resolve unit: push, resolve, table update, flush, stats.
interface branch_resolve_unit_if #(
  parameter int HIDX_W = 5,
  parameter int CIDX_W = 5
);
  import bpu_pkg::*;

  logic              pred_valid;
  logic              pred_ready;
  pc_t               pred_pc;
  logic              pred_taken;
  pc_t               pred_target;
  logic [HIDX_W-1:0] pred_hist_idx;
  logic [CIDX_W-1:0] pred_cnt_idx;
  logic [1:0]        pred_cnt_val;

  logic              res_valid;
  logic              res_taken;
  pc_t               res_target;

  logic              upd_valid;
  logic [HIDX_W-1:0] upd_hist_idx;
  logic              upd_hist_bit;
  logic [CIDX_W-1:0] upd_cnt_idx;
  logic [1:0]        upd_cnt_val;

  logic              flush;
  pc_t               flush_pc;
  logic [15:0]       branch_count;
  logic [15:0]       mispredict_count;
  logic              res_err;

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target, pred_hist_idx, pred_cnt_idx, pred_cnt_val,
    output res_valid, res_taken, res_target,
    input  pred_ready, upd_valid, upd_hist_idx, upd_hist_bit, upd_cnt_idx, upd_cnt_val,
    input  flush, flush_pc, branch_count, mispredict_count, res_err
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target, pred_hist_idx, pred_cnt_idx, pred_cnt_val,
    input  res_valid, res_taken, res_target,
    output pred_ready, upd_valid, upd_hist_idx, upd_hist_bit, upd_cnt_idx, upd_cnt_val,
    output flush, flush_pc, branch_count, mispredict_count, res_err
  );

endinterface

// File: rtl/branch_resolve_unit_branch_queue.sv
// In-order queue of predicted branches with wholesale clear and a CAM-style counter patch port.
module branch_queue
  import bpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  br_entry_t            push_entry,
  input  logic                 pop,
  input  logic                 clear,
  input  logic                 patch_en,
  input  logic [BR_CIDX_W-1:0] patch_idx,
  input  logic [1:0]           patch_val,
  output br_entry_t            head_entry,
  output logic                 full,
  output logic                 empty
);

  localparam int PTR_W = $clog2(DEPTH);

  br_entry_t        mem [DEPTH];
  br_entry_t        wr_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign empty      = (count == '0);
  assign head_entry = mem[head];

  // A push that aliases the counter being resolved must store the fresh value.
  always_comb begin
    wr_entry = push_entry;
    if (patch_en && push_entry.cnt_idx == patch_idx) wr_entry.cnt_val = patch_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + {PTR_W'(0), push} - {PTR_W'(0), pop};
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && !clear && tail == PTR_W'(i)) mem[i] <= wr_entry;
      else if (patch_en && mem[i].cnt_idx == patch_idx) mem[i].cnt_val <= patch_val;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves queued branch predictions: table write-back, mispredict flush and branch statistics.
module branch_resolve_unit
  import bpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int HIDX_W = BR_HIDX_W,
  parameter int CIDX_W = BR_CIDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_unit_if.slave  bus
);

  br_entry_t   push_entry;
  br_entry_t   head;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        mispredict;
  logic        clear;
  pc_t         actual_pc;
  logic [1:0]  new_cnt;

  logic              vld_p1;
  logic              flush_p1;
  pc_t               flush_pc_p1;
  logic [HIDX_W-1:0] upd_hist_idx_p1;
  logic              upd_hist_bit_p1;
  logic [CIDX_W-1:0] upd_cnt_idx_p1;
  logic [1:0]        upd_cnt_val_p1;
  logic [15:0]       branch_cnt;
  logic [15:0]       mispred_cnt;
  logic              err;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign push = bus.pred_valid && !full;
  assign pop  = bus.res_valid && !empty;

  assign push_entry = '{
    pc:       bus.pred_pc,
    taken:    bus.pred_taken,
    target:   bus.pred_target,
    hist_idx: BR_HIDX_W'(bus.pred_hist_idx),
    cnt_idx:  BR_CIDX_W'(bus.pred_cnt_idx),
    cnt_val:  bus.pred_cnt_val
  };

  branch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .clear      (clear),
    .patch_en   (pop),
    .patch_idx  (head.cnt_idx),
    .patch_val  (new_cnt),
    .head_entry (head),
    .full       (full),
    .empty      (empty)
  );

  // Resolve compare against the oldest queued prediction.
  assign new_cnt    = sat_update(head.cnt_val, bus.res_taken);
  assign actual_pc  = bus.res_taken ? bus.res_target : head.pc + 16'd1;
  assign mispredict = (head.taken != bus.res_taken) ||
                      (bus.res_taken && head.target != bus.res_target);
  assign clear      = pop && mispredict;

  // p1: registered write-back, flush and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1          <= 1'b0;
      flush_p1        <= 1'b0;
      flush_pc_p1     <= '0;
      upd_hist_idx_p1 <= '0;
      upd_hist_bit_p1 <= 1'b0;
      upd_cnt_idx_p1  <= '0;
      upd_cnt_val_p1  <= '0;
      branch_cnt      <= '0;
      mispred_cnt     <= '0;
      err             <= 1'b0;
    end else begin
      vld_p1      <= pop;
      flush_p1    <= clear;
      flush_pc_p1 <= clear ? actual_pc : '0;
      if (pop) begin
        upd_hist_idx_p1 <= head.hist_idx[HIDX_W-1:0];
        upd_hist_bit_p1 <= bus.res_taken;
        upd_cnt_idx_p1  <= head.cnt_idx[CIDX_W-1:0];
        upd_cnt_val_p1  <= new_cnt;
        branch_cnt      <= sat_inc16(branch_cnt);
        if (mispredict) mispred_cnt <= sat_inc16(mispred_cnt);
      end
      if (bus.res_valid && empty) err <= 1'b1;
    end
  end

  assign bus.pred_ready       = !full;
  assign bus.upd_valid        = vld_p1;
  assign bus.upd_hist_idx     = upd_hist_idx_p1;
  assign bus.upd_hist_bit     = upd_hist_bit_p1;
  assign bus.upd_cnt_idx      = upd_cnt_idx_p1;
  assign bus.upd_cnt_val      = upd_cnt_val_p1;
  assign bus.flush            = flush_p1;
  assign bus.flush_pc         = flush_pc_p1;
  assign bus.branch_count     = branch_cnt;
  assign bus.mispredict_count = mispred_cnt;
  assign bus.res_err          = err;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table, scoreboard and corner-case sequences.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  branch_resolve_unit_if #(.HIDX_W(5), .CIDX_W(5)) bus ();

  branch_resolve_unit #(.DEPTH(DEPTH), .HIDX_W(5), .CIDX_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        taken;
    logic [15:0] target;
    logic [4:0]  hidx;
    logic [4:0]  cidx;
    logic [1:0]  cval;
  } ent_t;

  typedef struct {
    logic [4:0]  hidx;
    logic [4:0]  cidx;
    logic [1:0]  cval;
    logic        hbit;
    logic        fl;
    logic [15:0] fpc;
  } exp_t;

  typedef struct {
    logic [15:0] pc;
    logic        taken;
    logic [15:0] target;
    logic [1:0]  cval;
    logic        rtaken;
    logic [15:0] rtarget;
    logic [1:0]  exp_cnt;
    logic        exp_flush;
    logic [15:0] exp_fpc;
  } vec_t;

  ent_t        mq[$];
  exp_t        sq[$];
  logic [15:0] m_bc;
  logic [15:0] m_mc;
  logic        m_err;
  int          n_chk;
  int          n_fail;
  vec_t        vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mreset();
    mq.delete();
    sq.delete();
    m_bc  = '0;
    m_mc  = '0;
    m_err = 1'b0;
  endtask

  task automatic idle();
    bus.pred_valid    = 1'b0;
    bus.pred_pc       = '0;
    bus.pred_taken    = 1'b0;
    bus.pred_target   = '0;
    bus.pred_hist_idx = '0;
    bus.pred_cnt_idx  = '0;
    bus.pred_cnt_val  = '0;
    bus.res_valid     = 1'b0;
    bus.res_taken     = 1'b0;
    bus.res_target    = '0;
  endtask

  task automatic set_push(input logic [15:0] pc, input logic taken, input logic [15:0] target,
                          input logic [4:0] hidx, input logic [4:0] cidx, input logic [1:0] cval);
    bus.pred_valid    = 1'b1;
    bus.pred_pc       = pc;
    bus.pred_taken    = taken;
    bus.pred_target   = target;
    bus.pred_hist_idx = hidx;
    bus.pred_cnt_idx  = cidx;
    bus.pred_cnt_val  = cval;
  endtask

  task automatic set_res(input logic taken, input logic [15:0] target);
    bus.res_valid  = 1'b1;
    bus.res_taken  = taken;
    bus.res_target = target;
  endtask

  // Advance one clock: update the reference model from the driven inputs, then check the DUT.
  task automatic tick();
    ent_t        e;
    ent_t        e2;
    ent_t        t;
    exp_t        x;
    logic [1:0]  nc;
    logic [15:0] apc;
    logic        mis;
    bit          was_empty;
    bit          do_pop;
    bit          do_push;
    bit          exp_upd;
    was_empty = (mq.size() == 0);
    do_pop    = bus.res_valid && !was_empty;
    do_push   = bus.pred_valid && (mq.size() < DEPTH);
    mis       = 1'b0;
    nc        = 2'd0;
    if (bus.res_valid && was_empty) m_err = 1'b1;
    if (do_pop) begin
      e = mq.pop_front();
      if (bus.res_taken) nc = (e.cval == 2'd3) ? 2'd3 : e.cval + 2'd1;
      else               nc = (e.cval == 2'd0) ? 2'd0 : e.cval - 2'd1;
      apc = bus.res_taken ? bus.res_target : e.pc + 16'd1;
      mis = (e.taken != bus.res_taken) || (bus.res_taken && (e.target != bus.res_target));
      for (int i = 0; i < mq.size(); i++) begin
        t = mq[i];
        if (t.cidx == e.cidx) t.cval = nc;
        mq[i] = t;
      end
      x.hidx = e.hidx;
      x.cidx = e.cidx;
      x.cval = nc;
      x.hbit = bus.res_taken;
      x.fl   = mis;
      x.fpc  = apc;
      sq.push_back(x);
      if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
      if (mis && m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
      if (mis) mq.delete();
    end
    if (do_push && !mis) begin
      e2.pc     = bus.pred_pc;
      e2.taken  = bus.pred_taken;
      e2.target = bus.pred_target;
      e2.hidx   = bus.pred_hist_idx;
      e2.cidx   = bus.pred_cnt_idx;
      e2.cval   = bus.pred_cnt_val;
      if (do_pop && e2.cidx == e.cidx) e2.cval = nc;
      mq.push_back(e2);
    end
    @(posedge clk);
    #1;
    exp_upd = (sq.size() != 0);
    chk("upd_valid", bus.upd_valid, exp_upd);
    if (exp_upd) begin
      x = sq.pop_front();
      chk("upd_hist_idx", bus.upd_hist_idx, x.hidx);
      chk("upd_hist_bit", bus.upd_hist_bit, x.hbit);
      chk("upd_cnt_idx", bus.upd_cnt_idx, x.cidx);
      chk("upd_cnt_val", bus.upd_cnt_val, x.cval);
      chk("flush", bus.flush, x.fl);
      if (x.fl) chk("flush_pc", bus.flush_pc, x.fpc);
    end else begin
      chk("flush_idle", bus.flush, 1'b0);
    end
    chk("pred_ready", bus.pred_ready, mq.size() < DEPTH);
    chk("branch_count", bus.branch_count, m_bc);
    chk("mispredict_count", bus.mispredict_count, m_mc);
    chk("res_err", bus.res_err, m_err);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_upd_valid"}, bus.upd_valid, 1'b0);
    chk({tag, "_flush"}, bus.flush, 1'b0);
    chk({tag, "_flush_pc"}, bus.flush_pc, 16'h0000);
    chk({tag, "_upd_hist_idx"}, bus.upd_hist_idx, 5'd0);
    chk({tag, "_upd_hist_bit"}, bus.upd_hist_bit, 1'b0);
    chk({tag, "_upd_cnt_idx"}, bus.upd_cnt_idx, 5'd0);
    chk({tag, "_upd_cnt_val"}, bus.upd_cnt_val, 2'd0);
    chk({tag, "_branch_count"}, bus.branch_count, 16'd0);
    chk({tag, "_mispredict_count"}, bus.mispredict_count, 16'd0);
    chk({tag, "_res_err"}, bus.res_err, 1'b0);
    chk({tag, "_pred_ready"}, bus.pred_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    //          pc        tk target    cv rtk rtarget   cnt fl fpc
    vecs[0] = '{16'h0010, 1, 16'h0040, 2, 1, 16'h0040, 3, 0, 16'h0000};
    vecs[1] = '{16'h0020, 0, 16'h0000, 1, 1, 16'h0008, 2, 1, 16'h0008};
    vecs[2] = '{16'hFFFF, 1, 16'h1234, 1, 0, 16'h0000, 0, 1, 16'h0000};
    vecs[3] = '{16'h0100, 1, 16'h0200, 3, 1, 16'h0300, 3, 1, 16'h0300};
    vecs[4] = '{16'h0050, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000};
    vecs[5] = '{16'h0060, 0, 16'h0000, 2, 0, 16'h0000, 1, 0, 16'h0000};

    idle();
    mreset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push/resolve vectors.
    for (int k = 0; k < 6; k++) begin
      set_push(vecs[k].pc, vecs[k].taken, vecs[k].target, 5'(k), 5'(k + 10), vecs[k].cval);
      tick();
      idle();
      set_res(vecs[k].rtaken, vecs[k].rtarget);
      tick();
      idle();
      chk("vec_cnt", bus.upd_cnt_val, vecs[k].exp_cnt);
      chk("vec_flush", bus.flush, vecs[k].exp_flush);
      if (vecs[k].exp_flush) chk("vec_flush_pc", bus.flush_pc, vecs[k].exp_fpc);
    end
    chk("table_branch_count", bus.branch_count, 16'd6);
    chk("table_mispredict_count", bus.mispredict_count, 16'd3);

    // Fill the queue, then mispredict the head while a fifth push is presented.
    for (int i = 0; i < 4; i++) begin
      set_push(16'h0200 + 16'(i), 1'b1, 16'h0300, 5'(i), 5'(20 + i), 2'd2);
      tick();
    end
    idle();
    chk("full_ready", bus.pred_ready, 1'b0);
    set_push(16'h0AAA, 1'b0, 16'h0000, 5'd31, 5'd31, 2'd1);
    set_res(1'b0, 16'h0000);
    tick();
    idle();
    chk("full_flush", bus.flush, 1'b1);
    chk("full_flush_pc", bus.flush_pc, 16'h0201);
    chk("after_flush_ready", bus.pred_ready, 1'b1);
    set_push(16'h0BBB, 1'b0, 16'h0000, 5'd17, 5'd17, 2'd2);
    tick();
    idle();
    set_res(1'b0, 16'h0000);
    tick();
    idle();
    chk("post_flush_entry", bus.upd_hist_idx, 5'd17);

    // Saturation at both ends on a shared counter index.
    set_push(16'h0300, 1'b0, 16'h0000, 5'd1, 5'd3, 2'd0);
    tick();
    set_push(16'h0301, 1'b0, 16'h0000, 5'd2, 5'd3, 2'd0);
    tick();
    idle();
    set_res(1'b0, 16'h0000);
    tick();
    chk("sat_low_a", bus.upd_cnt_val, 2'd0);
    tick();
    idle();
    chk("sat_low_b", bus.upd_cnt_val, 2'd0);
    set_push(16'h0302, 1'b1, 16'h0400, 5'd3, 5'd3, 2'd3);
    tick();
    idle();
    set_res(1'b1, 16'h0400);
    tick();
    idle();
    chk("sat_high", bus.upd_cnt_val, 2'd3);

    // Coherence: the second entry must see the first resolve's counter.
    set_push(16'h0500, 1'b1, 16'h0500, 5'd5, 5'd7, 2'd1);
    tick();
    set_push(16'h0501, 1'b1, 16'h0500, 5'd6, 5'd7, 2'd1);
    tick();
    idle();
    set_res(1'b1, 16'h0500);
    tick();
    chk("coh_first", bus.upd_cnt_val, 2'd2);
    tick();
    idle();
    chk("coh_second", bus.upd_cnt_val, 2'd3);

    // Same-edge push with a matching counter index.
    set_push(16'h0600, 1'b1, 16'h0600, 5'd8, 5'd9, 2'd1);
    tick();
    set_push(16'h0601, 1'b1, 16'h0600, 5'd4, 5'd9, 2'd1);
    set_res(1'b1, 16'h0600);
    tick();
    idle();
    chk("same_edge_first", bus.upd_cnt_val, 2'd2);
    set_res(1'b1, 16'h0600);
    tick();
    idle();
    chk("same_edge_second", bus.upd_cnt_val, 2'd3);

    // Resolve with an empty queue.
    set_res(1'b1, 16'h0000);
    tick();
    idle();
    chk("empty_res_err", bus.res_err, 1'b1);
    chk("empty_no_upd", bus.upd_valid, 1'b0);

    // Asynchronous reset with entries in flight.
    set_push(16'h0700, 1'b1, 16'h0710, 5'd10, 5'd10, 2'd2);
    tick();
    set_push(16'h0701, 1'b1, 16'h0710, 5'd11, 5'd11, 2'd2);
    set_res(1'b1, 16'h0710);
    tick();
    idle();
    #2 rst_n = 1'b0;
    #1;
    mreset();
    chk_reset_state("midreset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk_reset_state("post_reset");
    set_push(16'h0800, 1'b0, 16'h0000, 5'd12, 5'd12, 2'd1);
    tick();
    idle();
    set_res(1'b0, 16'h0000);
    tick();
    idle();
    chk("post_reset_entry", bus.upd_hist_idx, 5'd12);
    chk("post_reset_count", bus.branch_count, 16'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
